// File: rtl/mem_arbiter.sv
// ---- mem_arbiter: round-robin arbiter giving two request ports access to one data memory (rev 1.0) ----
`default_nettype none

module mem_arbiter #(
   parameter int DEPTH = 4001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_ack,
   output logic [31:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_ack,
   output logic [31:0] b_rdata,
   output logic        m_mem_read,
   output logic        m_mem_write,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata
);

   localparam logic [1:0]  S_IDLE  = 2'd0;
   localparam logic [1:0]  S_WR    = 2'd1;
   localparam logic [1:0]  S_RD    = 2'd2;
   localparam logic [1:0]  S_ACK   = 2'd3;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   logic [1:0]  state, state_nx;
   logic        owner;        // 0 = port A, 1 = port B
   logic        last_grant;
   logic        in_range;
   logic        any_req, grant_b, sel_we, sel_inr;
   logic [31:0] sel_addr, sel_wdata;
   logic        mem_read_nx, mem_write_nx, a_ack_nx, b_ack_nx;

   // B wins only when A is idle or A held the previous grant.
   always_comb begin
      any_req   = a_req | b_req;
      grant_b   = b_req & (~a_req | ~last_grant);
      sel_we    = grant_b ? b_we    : a_we;
      sel_addr  = grant_b ? b_addr  : a_addr;
      sel_wdata = grant_b ? b_wdata : a_wdata;
      sel_inr   = (sel_addr < DEPTH_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = S_IDLE;
      case (state)
         S_IDLE:  state_nx = any_req ? (sel_we ? S_WR : S_RD) : S_IDLE;
         S_WR:    state_nx = S_ACK;
         S_RD:    state_nx = S_ACK;
         S_ACK:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; strobes are suppressed for out-of-range addresses.
   always_comb begin
      mem_read_nx  = 1'b0;
      mem_write_nx = 1'b0;
      a_ack_nx     = 1'b0;
      b_ack_nx     = 1'b0;
      case (state)
         S_IDLE: begin
            mem_write_nx = any_req &  sel_we & sel_inr;
            mem_read_nx  = any_req & ~sel_we & sel_inr;
         end
         S_WR, S_RD: begin
            a_ack_nx = ~owner;
            b_ack_nx =  owner;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mem_read  <= 1'b0;
         m_mem_write <= 1'b0;
         a_ack       <= 1'b0;
         b_ack       <= 1'b0;
         m_addr      <= '0;
         m_wdata     <= '0;
         a_rdata     <= '0;
         b_rdata     <= '0;
         owner       <= 1'b0;
         last_grant  <= 1'b1;
         in_range    <= 1'b0;
      end else begin
         m_mem_read  <= mem_read_nx;
         m_mem_write <= mem_write_nx;
         a_ack       <= a_ack_nx;
         b_ack       <= b_ack_nx;
         if (state == S_IDLE && any_req) begin
            owner      <= grant_b;
            last_grant <= grant_b;
            in_range   <= sel_inr;
            m_addr     <= sel_addr;
            m_wdata    <= sel_wdata;
         end
         if (state == S_RD) begin
            if (owner) b_rdata <= in_range ? m_rdata : '0;
            else       a_rdata <= in_range ? m_rdata : '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ---- tb_mem_arbiter: directed self-checking bench for mem_arbiter (rev 1.0) ----
`default_nettype none

module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        a_req = 1'b0, a_we = 1'b0;
   logic [31:0] a_addr = '0, a_wdata = '0;
   logic        b_req = 1'b0, b_we = 1'b0;
   logic [31:0] b_addr = '0, b_wdata = '0;
   logic        a_ack, b_ack, m_mem_read, m_mem_write;
   logic [31:0] a_rdata, b_rdata, m_addr, m_wdata, m_rdata;

   int vecs = 0;
   int errs = 0;

   logic [31:0] mem [0:4095];

   mem_arbiter #(.DEPTH(4001)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .m_mem_read(m_mem_read), .m_mem_write(m_mem_write),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, write committed on the negedge inside the strobe.
   assign m_rdata = mem[m_addr[11:0]];
   always @(negedge clk) if (m_mem_write) mem[m_addr[11:0]] <= m_wdata;

   // Continuous protocol monitor: exclusive strobes, one-cycle acks, no overlapping acks.
   logic a_prev = 1'b0, b_prev = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         a_prev = 1'b0; b_prev = 1'b0;
      end else begin
         if (m_mem_read && m_mem_write) begin
            errs++; $display("FAIL strobe_excl: read=%0b write=%0b, required not both", m_mem_read, m_mem_write);
         end
         if (a_ack && a_prev) begin
            errs++; $display("FAIL a_ack_width: a_ack high two cycles, required one");
         end
         if (b_ack && b_prev) begin
            errs++; $display("FAIL b_ack_width: b_ack high two cycles, required one");
         end
         if (a_ack && b_ack) begin
            errs++; $display("FAIL ack_overlap: a_ack and b_ack both high, required exclusive");
         end
         a_prev = a_ack; b_prev = b_ack;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Runs one transaction on a port and reports what was seen; n = -1 means no ack within budget.
   task automatic do_port(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int n, output int wcnt, output int rcnt,
                          output logic [31:0] saddr, output logic [31:0] sdata, output logic [31:0] rdata);
      bit done;
      @(negedge clk);
      if (!port) begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
      else       begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
      n = 0; wcnt = 0; rcnt = 0; saddr = '0; sdata = '0; rdata = '0; done = 1'b0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
         if (m_mem_write) begin wcnt++; saddr = m_addr; sdata = m_wdata; end
         if (m_mem_read)  begin rcnt++; saddr = m_addr; end
         if ((!port && a_ack) || (port && b_ack)) begin
            rdata = port ? b_rdata : a_rdata;
            done  = 1'b1;
         end
      end
      if (!done) n = -1;
      if (!port) a_req = 1'b0; else b_req = 1'b0;
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      vecs++; if (m_mem_read !== 1'b0)  begin errs++; $display("FAIL rst_read: got %b exp 0", m_mem_read); end
      vecs++; if (m_mem_write !== 1'b0) begin errs++; $display("FAIL rst_write: got %b exp 0", m_mem_write); end
      vecs++; if (a_ack !== 1'b0)       begin errs++; $display("FAIL rst_a_ack: got %b exp 0", a_ack); end
      vecs++; if (b_ack !== 1'b0)       begin errs++; $display("FAIL rst_b_ack: got %b exp 0", b_ack); end
      vecs++; if (m_addr !== 32'h0)     begin errs++; $display("FAIL rst_m_addr: got %h exp 0", m_addr); end
      vecs++; if (m_wdata !== 32'h0)    begin errs++; $display("FAIL rst_m_wdata: got %h exp 0", m_wdata); end
      vecs++; if (a_rdata !== 32'h0)    begin errs++; $display("FAIL rst_a_rdata: got %h exp 0", a_rdata); end
      vecs++; if (b_rdata !== 32'h0)    begin errs++; $display("FAIL rst_b_rdata: got %h exp 0", b_rdata); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_write_read();
      int n, wc, rc;
      logic [31:0] sa, sd, rd;
      do_port(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, n, wc, rc, sa, sd, rd);
      vecs++; if (n !== 2)             begin errs++; $display("FAIL wr_latency: got %0d exp 2", n); end
      vecs++; if (wc !== 1 || rc !== 0) begin errs++; $display("FAIL wr_strobes: wr=%0d rd=%0d exp 1/0", wc, rc); end
      vecs++; if (sa !== 32'd5)        begin errs++; $display("FAIL wr_addr: got %h exp 5", sa); end
      vecs++; if (sd !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_data: got %h exp deadbeef", sd); end
      do_port(1'b0, 1'b0, 32'd5, 32'h0, n, wc, rc, sa, sd, rd);
      vecs++; if (n !== 2)              begin errs++; $display("FAIL rd_latency: got %0d exp 2", n); end
      vecs++; if (rc !== 1 || wc !== 0) begin errs++; $display("FAIL rd_strobes: rd=%0d wr=%0d exp 1/0", rc, wc); end
      vecs++; if (sa !== 32'd5)         begin errs++; $display("FAIL rd_addr: got %h exp 5", sa); end
      vecs++; if (rd !== 32'hDEADBEEF)  begin errs++; $display("FAIL rd_data: got %h exp deadbeef", rd); end
   endtask

   task automatic test_tie();
      int ta = -1, tb = -1;
      logic [31:0] ra = '0, rb = '0;
      apply_reset();
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'd7;
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'd9;
      for (int i = 1; i <= 20 && (ta < 0 || tb < 0); i++) begin
         @(negedge clk);
         if (a_ack) begin ta = i; ra = a_rdata; a_req = 1'b0; end
         if (b_ack) begin tb = i; rb = b_rdata; b_req = 1'b0; end
      end
      a_req = 1'b0; b_req = 1'b0;
      vecs++; if (ta !== 2)            begin errs++; $display("FAIL tie_a_first: a_ack cycle %0d exp 2", ta); end
      vecs++; if (tb !== 5)            begin errs++; $display("FAIL tie_b_next: b_ack cycle %0d exp 5", tb); end
      vecs++; if (ra !== 32'hA5A50007) begin errs++; $display("FAIL tie_a_data: got %h exp a5a50007", ra); end
      vecs++; if (rb !== 32'h5A5A0009) begin errs++; $display("FAIL tie_b_data: got %h exp 5a5a0009", rb); end
   endtask

   task automatic test_fairness();
      logic [7:0] order [0:5];
      logic [7:0] exp_ch;
      int cnt = 0;
      apply_reset();
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'd7;
      b_req = 1'b1; b_we = 1'b0; b_addr = 32'd9;
      for (int i = 0; i < 40 && cnt < 6; i++) begin
         @(negedge clk);
         if (a_ack) begin order[cnt] = "A"; cnt++; end
         else if (b_ack) begin order[cnt] = "B"; cnt++; end
      end
      a_req = 1'b0; b_req = 1'b0;
      vecs++; if (cnt !== 6) begin errs++; $display("FAIL rr_count: got %0d grants exp 6", cnt); end
      for (int i = 0; i < cnt; i++) begin
         exp_ch = (i % 2 == 0) ? "A" : "B";
         vecs++;
         if (order[i] !== exp_ch) begin errs++; $display("FAIL rr_order[%0d]: got %c exp %c", i, order[i], exp_ch); end
      end
   endtask

   task automatic test_boundary();
      int n, wc, rc;
      logic [31:0] sa, sd, rd;
      do_port(1'b0, 1'b1, 32'd4000, 32'h0BADF00D, n, wc, rc, sa, sd, rd);
      vecs++; if (wc !== 1 || sa !== 32'd4000) begin errs++; $display("FAIL edge_wr: wr=%0d addr=%h exp 1/4000", wc, sa); end
      do_port(1'b0, 1'b0, 32'd4000, 32'h0, n, wc, rc, sa, sd, rd);
      vecs++; if (rc !== 1 || rd !== 32'h0BADF00D) begin errs++; $display("FAIL edge_rd: rd=%0d data=%h exp 1/0badf00d", rc, rd); end
      do_port(1'b0, 1'b1, 32'd4001, 32'hFFFF0000, n, wc, rc, sa, sd, rd);
      vecs++; if (n !== 2 || wc !== 0) begin errs++; $display("FAIL oor_wr: cycles=%0d wr=%0d exp 2/0", n, wc); end
      vecs++; if (mem[4001] !== 32'h12345678) begin errs++; $display("FAIL oor_mem: got %h exp 12345678", mem[4001]); end
      do_port(1'b1, 1'b0, 32'd4001, 32'h0, n, wc, rc, sa, sd, rd);
      vecs++; if (n !== 2)  begin errs++; $display("FAIL oor_rd_ack: cycles=%0d exp 2", n); end
      vecs++; if (rc !== 0) begin errs++; $display("FAIL oor_rd_strobe: got %0d exp 0", rc); end
      vecs++; if (rd !== 32'h0) begin errs++; $display("FAIL oor_b_rdata: got %h exp 0", rd); end
      vecs++; if (a_rdata !== 32'h0BADF00D) begin errs++; $display("FAIL a_rdata_hold: got %h exp 0badf00d", a_rdata); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'd7;
      @(negedge clk);
      vecs++; if (m_mem_read !== 1'b1 || m_addr !== 32'd7) begin errs++; $display("FAIL mid_in_rd: read=%b addr=%h exp 1/7", m_mem_read, m_addr); end
      #2 rst_n = 1'b0;
      #1;
      vecs++; if (m_mem_read !== 1'b0) begin errs++; $display("FAIL mid_read_clr: got %b exp 0", m_mem_read); end
      vecs++; if (m_addr !== 32'h0)    begin errs++; $display("FAIL mid_addr_clr: got %h exp 0", m_addr); end
      vecs++; if (a_rdata !== 32'h0)   begin errs++; $display("FAIL mid_a_rdata_clr: got %h exp 0", a_rdata); end
      @(negedge clk);
      vecs++; if (a_ack !== 1'b0) begin errs++; $display("FAIL mid_no_ack: got %b exp 0", a_ack); end
      rst_n = 1'b1;
      @(negedge clk);
      vecs++; if (m_mem_read !== 1'b1 || m_addr !== 32'd7) begin errs++; $display("FAIL mid_regrant: read=%b addr=%h exp 1/7", m_mem_read, m_addr); end
      @(negedge clk);
      vecs++; if (a_ack !== 1'b1 || a_rdata !== 32'hA5A50007) begin errs++; $display("FAIL mid_ack: ack=%b data=%h exp 1/a5a50007", a_ack, a_rdata); end
      a_req = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[7]    = 32'hA5A50007;
      mem[9]    = 32'h5A5A0009;
      mem[4001] = 32'h12345678;
      test_reset();
      test_write_read();
      test_tie();
      test_fairness();
      test_boundary();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

`default_nettype wire
